// File: rtl/ysyx_210238_ram_resp_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_210238_ram_resp_pkg
//   Shared definitions for the load/store RAM responder: access size codes,
//   FSM state encodings and the byte-lane helper functions used to place
//   right-aligned store data into a 64-bit word and to pull right-aligned
//   load data back out of it.
// ---------------------------------------------------------------------------
package ysyx_210238_ram_resp_pkg;

  // Access size codes carried on i_ram_size. Codes above SIZE_D are illegal.
  localparam logic [2:0] SIZE_B = 3'd0;  // 1 byte
  localparam logic [2:0] SIZE_H = 3'd1;  // 2 bytes
  localparam logic [2:0] SIZE_W = 3'd2;  // 4 bytes
  localparam logic [2:0] SIZE_D = 3'd3;  // 8 bytes

  // Responder FSM states. Encoding 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-enable mask for an access of the given size at lane offset off:
  // (2^(2^size) - 1) << off. Illegal sizes give an empty mask.
  function automatic logic [7:0] lane_mask(input logic [2:0] size,
                                           input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      SIZE_W:  base = 8'h0f;
      SIZE_D:  base = 8'hff;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Bit mask covering the access width, used to zero-fill load data above
  // the requested size.
  function automatic logic [63:0] width_mask(input logic [2:0] size);
    logic [63:0] m;
    case (size)
      SIZE_B:  m = 64'h0000_0000_0000_00ff;
      SIZE_H:  m = 64'h0000_0000_0000_ffff;
      SIZE_W:  m = 64'h0000_0000_ffff_ffff;
      SIZE_D:  m = 64'hffff_ffff_ffff_ffff;
      default: m = 64'h0;
    endcase
    return m;
  endfunction

  // Shift amount in bits for a byte lane offset (8 * off).
  function automatic logic [5:0] lane_shift(input logic [2:0] off);
    return {off, 3'b000};
  endfunction

  // A request is in error when its size code is illegal or its lane offset
  // is not a multiple of the access width.
  function automatic logic req_error(input logic [2:0] size,
                                     input logic [2:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = |off[1:0];
      SIZE_D:  bad = |off[2:0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_210238_ram_resp_array.sv
// ---------------------------------------------------------------------------
// ysyx_210238_ram_array
//   DEPTH x 64-bit word store with one shared index. Writes are synchronous
//   with a per-byte enable; reads are combinational on the same index. Kept
//   as its own module so a hard memory macro can be dropped in later.
//
//   clk      : write clock
//   i_we     : write strobe for this cycle
//   i_be     : byte enables, bit b covers i_wdata[8b +: 8]
//   i_idx    : word index (read and write)
//   i_wdata  : lane-aligned write data
//   o_rdata  : word currently addressed by i_idx
//
//   Contents are intentionally not reset.
// ---------------------------------------------------------------------------
module ysyx_210238_ram_array #(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [7:0]       i_be,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [63:0]      i_wdata,
  output logic [63:0]      o_rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_be[b]) begin
          mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = mem[i_idx];

endmodule

// File: rtl/ysyx_210238_ram_resp.sv
// ---------------------------------------------------------------------------
// ysyx_210238_ram_resp
//   Data-memory responder for the core's load/store RAM port. A request is
//   latched in IDLE, held for LATENCY cycles, then completed in RESP where
//   the store is committed and the response pulse is raised.
//
//   Handshake: i_ram_valid is a one-cycle request strobe that is only
//   sampled in IDLE; it is neither queued nor back-pressured while a request
//   is in flight. o_ram_ready is a one-cycle completion pulse raised exactly
//   LATENCY cycles after the accepted strobe; o_ram_rdata and o_ram_err are
//   meaningful in that same cycle. The earliest next request is the cycle
//   after o_ram_ready.
//
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_ram_valid  : request strobe
//   i_ram_wen    : 1 = store, 0 = load
//   i_ram_addr   : byte address (word index in addr[3 +: log2(DEPTH)])
//   i_ram_size   : 0 byte, 1 half, 2 word, 3 double; others illegal
//   i_ram_wdata  : right-aligned store data
//   o_ram_ready  : completion pulse
//   o_ram_rdata  : right-aligned, zero-filled load data (held until the
//                  next successful load)
//   o_ram_err    : misaligned or illegal-size request, pulses with ready
// ---------------------------------------------------------------------------
module ysyx_210238_ram_resp
  import ysyx_210238_ram_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ram_valid,
  input  logic        i_ram_wen,
  input  logic [63:0] i_ram_addr,
  input  logic [2:0]  i_ram_size,
  input  logic [63:0] i_ram_wdata,
  output logic        o_ram_ready,
  output logic [63:0] o_ram_rdata,
  output logic        o_ram_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // Counter only needs to hold LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // FSM and request registers
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        addr_q, addr_d;
  logic [2:0]         size_q, size_d;
  logic               wen_q, wen_d;
  logic [63:0]        wdata_q, wdata_d;

  // Registered response outputs
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [63:0]        rdata_q, rdata_d;

  // Array interface
  logic               arr_we;
  logic [7:0]         arr_be;
  logic [IDX_W-1:0]   arr_idx;
  logic [63:0]        arr_wdata;
  logic [63:0]        arr_rdata;

  // Response data derived from the request that is about to enter RESP
  logic               nxt_err;
  logic [63:0]        nxt_load;
  logic               cur_err;

  // Address bits above the word index alias and are deliberately dropped.
  logic               unused_addr_hi;
  assign unused_addr_hi = ^addr_q[63:IDX_W+3];

  // -------------------------------------------------------------------------
  // Next-state / request capture
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ram_valid) begin
          addr_d  = i_ram_addr;
          size_d  = i_ram_size;
          wen_d   = i_ram_wen;
          wdata_d = i_ram_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The decrement that brings the counter to zero is also the cycle
        // that moves to RESP, so ready lands exactly LATENCY cycles after
        // the accepted strobe.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  // The array index follows the _d request so that with LATENCY=1 the read
  // can be registered on the same edge that accepts the request. In RESP no
  // new request is captured, so addr_d equals addr_q and the store commits
  // to the latched word.
  assign arr_idx   = addr_d[3 +: IDX_W];
  assign cur_err   = req_error(size_q, addr_q[2:0]);
  assign arr_we    = (state_q == ST_RESP) && wen_q && !cur_err;
  assign arr_be    = lane_mask(size_q, addr_q[2:0]);
  assign arr_wdata = wdata_q << lane_shift(addr_q[2:0]);

  assign nxt_err  = req_error(size_d, addr_d[2:0]);
  assign nxt_load = (arr_rdata >> lane_shift(addr_d[2:0])) & width_mask(size_d);

  // Response outputs are computed on entry to RESP and registered, so they
  // are valid for the whole RESP cycle with no path from the inputs.
  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (state_d == ST_RESP) begin
      ready_d = 1'b1;
      err_d   = nxt_err;
      if (!nxt_err && !wen_d) begin
        rdata_d = nxt_load;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  ysyx_210238_ram_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (arr_we),
    .i_be    (arr_be),
    .i_idx   (arr_idx),
    .i_wdata (arr_wdata),
    .o_rdata (arr_rdata)
  );

  assign o_ram_ready = ready_q;
  assign o_ram_err   = err_q;
  assign o_ram_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_210238_ram_resp.sv
// ---------------------------------------------------------------------------
// tb_ysyx_210238_ram_resp
//   Two instances: dut (LATENCY=2) carries the table, corner-case and random
//   traffic; dut1 (LATENCY=1) covers single-cycle latency and back-to-back
//   turnaround. The reference memory is a plain byte-addressed model.
// ---------------------------------------------------------------------------
module tb_ysyx_210238_ram_resp;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT (LATENCY=2) ----------------
  logic        valid, wen;
  logic [63:0] addr, wdata;
  logic [2:0]  size;
  logic        ready, err;
  logic [63:0] rdata;

  ysyx_210238_ram_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ram_valid(valid), .i_ram_wen(wen), .i_ram_addr(addr),
    .i_ram_size(size), .i_ram_wdata(wdata),
    .o_ram_ready(ready), .o_ram_rdata(rdata), .o_ram_err(err)
  );

  // ---------------- DUT (LATENCY=1) ----------------
  logic        v1_valid, v1_wen;
  logic [63:0] v1_addr, v1_wdata;
  logic [2:0]  v1_size;
  logic        v1_ready, v1_err;
  logic [63:0] v1_rdata;

  ysyx_210238_ram_resp #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_ram_valid(v1_valid), .i_ram_wen(v1_wen), .i_ram_addr(v1_addr),
    .i_ram_size(v1_size), .i_ram_wdata(v1_wdata),
    .o_ram_ready(v1_ready), .o_ram_rdata(v1_rdata), .o_ram_err(v1_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] model_mem [DEPTH];
  logic [63:0] last_rdata = 64'h0;

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  function automatic logic model_err(input logic [63:0] a, input logic [2:0] s);
    int n;
    if (s > 3) return 1'b1;
    n = 1 << s;
    return (int'(a[2:0]) % n) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] s);
    logic [63:0] r = 64'h0;
    int w = word_of(a);
    int base = int'(a[2:0]);
    for (int i = 0; i < (1 << s); i++) r[8*i +: 8] = model_mem[w][8*(base+i) +: 8];
    return r;
  endfunction

  task automatic model_store(input logic [63:0] a, input logic [2:0] s, input logic [63:0] d);
    int w = word_of(a);
    int base = int'(a[2:0]);
    for (int i = 0; i < (1 << s); i++) model_mem[w][8*(base+i) +: 8] = d[8*i +: 8];
  endtask

  // Applies one request to the model; returns {err, rdata} expected at ready.
  task automatic run_model(input logic w, input logic [63:0] a, input logic [2:0] s,
                           input logic [63:0] d, output logic [64:0] e);
    logic bad = model_err(a, s);
    if (!bad && !w) last_rdata = model_load(a, s);
    else if (!bad && w) model_store(a, s, d);
    e = {bad, last_rdata};
  endtask

  // ---------------- driver tasks ----------------
  // Drives a one-cycle strobe at a negedge and samples each following
  // negedge until ready; lat = cycles from strobe to ready, -1 on timeout.
  task automatic do_req(input logic w, input logic [63:0] a, input logic [2:0] s,
                        input logic [63:0] d, output logic g_err,
                        output logic [63:0] g_rdata, output int lat);
    @(negedge clk);
    valid = 1'b1; wen = w; addr = a; size = s; wdata = d;
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!ready) lat = -1;
    g_err = err;
    g_rdata = rdata;
  endtask

  task automatic do_req1(input logic w, input logic [63:0] a, input logic [2:0] s,
                         input logic [63:0] d, output logic g_err,
                         output logic [63:0] g_rdata, output int lat);
    @(negedge clk);
    v1_valid = 1'b1; v1_wen = w; v1_addr = a; v1_size = s; v1_wdata = d;
    @(negedge clk);
    v1_valid = 1'b0;
    lat = 1;
    while (!v1_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!v1_ready) lat = -1;
    g_err = v1_err;
    g_rdata = v1_rdata;
  endtask

  // Checked request against the model via the expected queue.
  task automatic sb_req(input string tag, input logic w, input logic [63:0] a,
                        input logic [2:0] s, input logic [63:0] d);
    logic [64:0] e;
    logic g_err;
    logic [63:0] g_rdata;
    int lat;
    run_model(w, a, s, d, e);
    exp_q.push_back(e);
    do_req(w, a, s, d, g_err, g_rdata, lat);
    e = exp_q.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_err"}, {63'h0, g_err}, {63'h0, e[64]});
    check({tag, "_rdata"}, g_rdata, e[63:0]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic        g_err;
    logic [63:0] g_rdata;
    logic [64:0] e;
    int          lat, nready, c0;

    valid = 0; wen = 0; addr = 0; size = 0; wdata = 0;
    v1_valid = 0; v1_wen = 0; v1_addr = 0; v1_size = 0; v1_wdata = 0;

    vecs[0]  = '{1'b1, 64'h80, 3'd3, 64'h1122334455667788, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 64'h80, 3'd3, 64'h0,                1'b0, 64'h1122334455667788};
    vecs[2]  = '{1'b1, 64'h10, 3'd3, 64'hffffffffffffffff, 1'b0, 64'h1122334455667788};
    vecs[3]  = '{1'b1, 64'h13, 3'd0, 64'h00000000000000ab, 1'b0, 64'h1122334455667788};
    vecs[4]  = '{1'b0, 64'h10, 3'd3, 64'h0,                1'b0, 64'hffffffffabffffff};
    vecs[5]  = '{1'b0, 64'h13, 3'd0, 64'h0,                1'b0, 64'h00000000000000ab};
    vecs[6]  = '{1'b1, 64'h20, 3'd3, 64'h8877665544332211, 1'b0, 64'h00000000000000ab};
    vecs[7]  = '{1'b0, 64'h26, 3'd1, 64'h0,                1'b0, 64'h0000000000008877};
    vecs[8]  = '{1'b0, 64'h24, 3'd2, 64'h0,                1'b0, 64'h0000000088776655};
    vecs[9]  = '{1'b1, 64'h22, 3'd2, 64'h00000000cafebabe, 1'b1, 64'h0000000088776655};
    vecs[10] = '{1'b0, 64'h20, 3'd3, 64'h0,                1'b0, 64'h8877665544332211};
    vecs[11] = '{1'b0, 64'h20, 3'd5, 64'h0,                1'b1, 64'h8877665544332211};
    vecs[12] = '{1'b0, 64'h24, 3'd3, 64'h0,                1'b1, 64'h8877665544332211};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset_ready", {63'h0, ready}, 64'h0);
    check("reset_err", {63'h0, err}, 64'h0);
    check("reset_rdata", rdata, 64'h0);
    check("reset_ready_lat1", {63'h0, v1_ready}, 64'h0);
    rst_n = 1'b1;

    // ---- table vectors (LATENCY=2) ----
    for (int i = 0; i < 13; i++) begin
      run_model(vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].wdata, e);
      do_req(vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].wdata, g_err, g_rdata, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_err", i), {63'h0, g_err}, {63'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
    end

    // ---- valid during WAIT is ignored; one ready only ----
    @(negedge clk);
    valid = 1'b1; wen = 1'b0; addr = 64'h80; size = 3'd3; wdata = 64'h0;
    @(negedge clk);
    wen = 1'b1; wdata = 64'h0bad0bad0bad0bad;   // second strobe lands in WAIT
    @(negedge clk);
    valid = 1'b0;
    nready = 0;
    for (int k = 0; k < 6; k++) begin
      if (ready) nready++;
      @(negedge clk);
    end
    check("wait_ignore_ready_count", 64'(nready), 64'd1);
    last_rdata = model_load(64'h80, 3'd3);
    check("wait_ignore_rdata", rdata, last_rdata);
    sb_req("wait_ignore_reload", 1'b0, 64'h80, 3'd3, 64'h0);

    // ---- reset asserted during WAIT of a store ----
    @(negedge clk);
    valid = 1'b1; wen = 1'b1; addr = 64'h80; size = 3'd3; wdata = 64'hdeadbeefdeadbeef;
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_wait_ready", {63'h0, ready}, 64'h0);
    check("rst_wait_err", {63'h0, err}, 64'h0);
    check("rst_wait_rdata", rdata, 64'h0);
    nready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    check("rst_wait_no_ready", 64'(nready), 64'd0);
    last_rdata = 64'h0;
    sb_req("rst_wait_word", 1'b0, 64'h80, 3'd3, 64'h0);

    // ---- reset asserted in RESP before the commit edge ----
    @(negedge clk);
    valid = 1'b1; wen = 1'b1; addr = 64'h80; size = 3'd3; wdata = 64'h5555aaaa5555aaaa;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("rst_resp_ready_seen", {63'h0, ready}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_ready_cleared", {63'h0, ready}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 64'h0;
    sb_req("rst_resp_word", 1'b0, 64'h80, 3'd3, 64'h0);

    // ---- LATENCY=1: single-cycle response, 2-cycle turnaround ----
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      logic [63:0] d = {$urandom(), $urandom()};
      do_req1(1'b1, 64'h40 + 64'(8*i), 3'd3, d, g_err, g_rdata, lat);
      if (i == 0) c0 = cyc;
      check($sformatf("lat1_st%0d_lat", i), 64'(lat), 64'd1);
      check($sformatf("lat1_st%0d_err", i), {63'h0, g_err}, 64'h0);
      do_req1(1'b0, 64'h40 + 64'(8*i), 3'd3, 64'h0, g_err, g_rdata, lat);
      check($sformatf("lat1_ld%0d_lat", i), 64'(lat), 64'd1);
      check($sformatf("lat1_ld%0d_rdata", i), g_rdata, d);
    end
    check("lat1_turnaround_cycles", 64'(cyc - c0), 64'd14);

    // ---- randomized traffic vs model (words 0..15, aliased high bits) ----
    for (int w = 0; w < 16; w++) begin
      logic [63:0] a = {$urandom(), $urandom()};
      a[12:0] = {10'(w), 3'b000};
      sb_req("preload", 1'b1, a, 3'd3, {$urandom(), $urandom()});
    end
    for (int n = 0; n < 150; n++) begin
      logic [63:0] a = {$urandom(), $urandom()};
      logic [2:0]  s;
      logic [2:0]  off;
      s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      off = 3'($urandom_range(0, 7));
      if (s <= 3 && $urandom_range(0, 3) != 0) off = off & ~3'((1 << s) - 1);
      a[12:0] = {10'($urandom_range(0, 15)), off};
      sb_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, s, {$urandom(), $urandom()});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
